// File: rtl/ctrl_cancela.sv
// ---------------------------------------------------------------------------
// ctrl_cancela
//   Gate controller for the parking-lot counter path. Grants the single
//   shared barrier sequence to either the entry or the exit side, alternating
//   on simultaneous requests, and issues one count command per completed
//   passage to the BCD occupancy counter. Entry is refused while full.
//
//   Optional feature macro: CTRL_DEBOUNCE_EN
//     defined   -> counter debounce filter on the synchronized pass loops
//     undefined -> synchronizer outputs drive the FSM directly
//
// Parameters
//   TIMEOUT     cycles an unused barrier stays open before giving up
//   DEB_CYCLES  stable cycles required by the debounce filter
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high
//   req_ent      vehicle at the entry loop (async)
//   pass_ent     vehicle under/after the entry barrier (async)
//   req_sai      vehicle at the exit loop (async)
//   pass_sai     vehicle under/after the exit barrier (async)
//   cheio        occupancy counter at capacity
//   cancela_ent  entry barrier open
//   cancela_sai  exit barrier open
//   somar        count enable, one-cycle pulse
//   decrem       count direction, 1 = decrement (valid with somar)
//   lotado       registered copy of cheio
//   ocupado      FSM busy (not IDLE)
//
// State        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | barriers closed, arbitrating pending requests
// ABRE_ENT     | entry barrier open, waiting for the car (timed)
// PASSA_ENT    | car under the entry barrier, no timeout
// CONTA_ENT    | entry barrier closed, increment pulse
// ABRE_SAI     | exit barrier open, waiting for the car (timed)
// PASSA_SAI    | car under the exit barrier, no timeout
// CONTA_SAI    | exit barrier closed, decrement pulse
// ---------------------------------------------------------------------------
module ctrl_cancela #(
    parameter int unsigned TIMEOUT    = 250_000_000,
    parameter int unsigned DEB_CYCLES = 50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic req_ent,
    input  logic pass_ent,
    input  logic req_sai,
    input  logic pass_sai,
    input  logic cheio,
    output logic cancela_ent,
    output logic cancela_sai,
    output logic somar,
    output logic decrem,
    output logic lotado,
    output logic ocupado
);

    typedef enum logic [2:0] {
        IDLE,
        ABRE_ENT,
        PASSA_ENT,
        CONTA_ENT,
        ABRE_SAI,
        PASSA_SAI,
        CONTA_SAI
    } state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    // bit order: 0 req_ent, 1 pass_ent, 2 req_sai, 3 pass_sai
    logic [3:0] sync1, sync2;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic          ult_grant, ult_next;   // 0: entry served last, 1: exit
    logic          p_ent, p_sai;
    logic          elig_ent, elig_sai;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {pass_sai, req_sai, pass_ent, req_ent};
            sync2 <= sync1;
        end
    end

`ifdef CTRL_DEBOUNCE_EN
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [1:0]    pass_raw, pass_filt;
    logic [DW-1:0] deb_cnt [2];

    assign pass_raw = {sync2[3], sync2[1]};

    // The count restarts whenever raw agrees with the filtered level, so the
    // output only moves after DEB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_filt  <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pass_raw[i] == pass_filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    pass_filt[i] <= pass_raw[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign p_ent = pass_filt[0];
    assign p_sai = pass_filt[1];
`else
    logic unused_deb;
    assign unused_deb = ^DEB_CYCLES;
    assign p_ent      = sync2[1];
    assign p_sai      = sync2[3];
`endif

    // cheio comes from synchronous occupancy logic, so it is used unsynced
    assign elig_ent = sync2[0] & ~cheio;
    assign elig_sai = sync2[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            ult_grant <= 1'b0;
            lotado    <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            ult_grant <= ult_next;
            lotado    <= cheio;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = '0;
        ult_next   = ult_grant;
        case (state)
            IDLE: begin
                if (elig_ent && elig_sai) begin
                    if (ult_grant) begin
                        state_next = ABRE_ENT;
                        ult_next   = 1'b0;
                    end else begin
                        state_next = ABRE_SAI;
                        ult_next   = 1'b1;
                    end
                end else if (elig_ent) begin
                    state_next = ABRE_ENT;
                    ult_next   = 1'b0;
                end else if (elig_sai) begin
                    state_next = ABRE_SAI;
                    ult_next   = 1'b1;
                end
            end
            ABRE_ENT: begin
                if (p_ent) begin
                    state_next = PASSA_ENT;
                end else if (timer == T_LAST) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            PASSA_ENT: begin
                if (!p_ent) begin
                    state_next = CONTA_ENT;
                end
            end
            CONTA_ENT: begin
                state_next = IDLE;
            end
            ABRE_SAI: begin
                if (p_sai) begin
                    state_next = PASSA_SAI;
                end else if (timer == T_LAST) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            PASSA_SAI: begin
                if (!p_sai) begin
                    state_next = CONTA_SAI;
                end
            end
            CONTA_SAI: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Decoded straight from the state register: glitch-free and cleared the
    // moment reset forces IDLE.
    assign cancela_ent = (state == ABRE_ENT) || (state == PASSA_ENT);
    assign cancela_sai = (state == ABRE_SAI) || (state == PASSA_SAI);
    assign somar       = (state == CONTA_ENT) || (state == CONTA_SAI);
    assign decrem      = (state == CONTA_SAI);
    assign ocupado     = (state != IDLE);

endmodule

// File: tb/tb_ctrl_cancela.sv
module tb_ctrl_cancela;

    localparam int T = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_ent = 1'b0, pass_ent = 1'b0, req_sai = 1'b0, pass_sai = 1'b0, cheio = 1'b0;
    logic cancela_ent, cancela_sai, somar, decrem, lotado, ocupado;

    ctrl_cancela #(.TIMEOUT(T), .DEB_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_ent     (req_ent),
        .pass_ent    (pass_ent),
        .req_sai     (req_sai),
        .pass_sai    (pass_sai),
        .cheio       (cheio),
        .cancela_ent (cancela_ent),
        .cancela_sai (cancela_sai),
        .somar       (somar),
        .decrem      (decrem),
        .lotado      (lotado),
        .ocupado     (ocupado)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {cancela_ent, cancela_sai, somar, decrem, lotado, ocupado};
    endfunction

    task automatic drive(input logic [4:0] v);
        {req_ent, pass_ent, req_sai, pass_sai, cheio} = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(5'b00000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- reference model (transaction view) ----------------
    // side: -1 nobody granted, 0 entry, 1 exit
    int       m_side, m_open, m_last;
    bit       m_seen, m_count, m_lot;
    bit [3:0] md1, md2;   // pin values one and two edges back

    task automatic model_reset();
        m_side = -1; m_open = 0; m_last = 0;
        m_seen = 0;  m_count = 0; m_lot = 0;
        md1 = '0;    md2 = '0;
    endtask

    // pins: {pass_sai, req_sai, pass_ent, req_ent}; called once per clock edge
    task automatic model_step(input bit [3:0] pins, input bit ch);
        bit [3:0] s;
        bit ee, es, sp;
        s = md2;
        if (m_count) begin
            m_count = 0;
            m_side  = -1;
        end else if (m_side < 0) begin
            ee = s[0] && !ch;
            es = s[2];
            if (ee && es)  m_side = (m_last == 0) ? 1 : 0;
            else if (ee)   m_side = 0;
            else if (es)   m_side = 1;
            if (m_side >= 0) begin
                m_last = m_side;
                m_open = 0;
                m_seen = 0;
            end
        end else begin
            sp = (m_side == 0) ? s[1] : s[3];
            if (!m_seen) begin
                if (sp)                 m_seen = 1;
                else if (m_open == T-1) m_side = -1;
                else                    m_open++;
            end else if (!sp) begin
                m_count = 1;
            end
        end
        md2   = md1;
        md1   = pins;
        m_lot = ch;
    endtask

    function automatic logic [5:0] model_out();
        return {m_side == 0 && !m_count, m_side == 1 && !m_count, m_count,
                m_count && m_side == 1, m_lot, m_side != -1};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [4:0] in;    // {req_ent, pass_ent, req_sai, pass_sai, cheio}
        logic [5:0] exp;   // {cancela_ent, cancela_sai, somar, decrem, lotado, ocupado}
    } vec_t;

    vec_t tbl [29];

    initial begin
        int first_hi, hi_cnt, pulse_cnt, npulse, ke, ks;
        int ord [3];
        bit both, got;
        bit [3:0] pins;
        bit ch;

        // entry passage
        tbl[0]  = '{5'b10000, 6'b000000};
        tbl[1]  = '{5'b10000, 6'b000000};
        tbl[2]  = '{5'b10000, 6'b100001};
        for (int i = 3; i <= 7; i++) tbl[i] = '{5'b01000, 6'b100001};
        tbl[8]  = '{5'b00000, 6'b100001};
        tbl[9]  = '{5'b00000, 6'b100001};
        tbl[10] = '{5'b00000, 6'b001001};
        tbl[11] = '{5'b00000, 6'b000000};
        tbl[12] = '{5'b00000, 6'b000000};
        // exit passage
        tbl[13] = '{5'b00100, 6'b000000};
        tbl[14] = '{5'b00100, 6'b000000};
        tbl[15] = '{5'b00100, 6'b010001};
        tbl[16] = '{5'b00010, 6'b010001};
        tbl[17] = '{5'b00010, 6'b010001};
        tbl[18] = '{5'b00000, 6'b010001};
        tbl[19] = '{5'b00000, 6'b010001};
        tbl[20] = '{5'b00000, 6'b001101};
        tbl[21] = '{5'b00000, 6'b000000};
        // lot full: entry refused, exit still served
        for (int i = 22; i <= 25; i++) tbl[i] = '{5'b10001, 6'b000010};
        tbl[26] = '{5'b10101, 6'b000010};
        tbl[27] = '{5'b10101, 6'b000010};
        tbl[28] = '{5'b10101, 6'b010011};

        #12;
        check("reset_outputs", {26'd0, outs()}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            drive(tbl[i].in);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {26'd0, outs()}, {26'd0, tbl[i].exp});
        end

        // timeout with no vehicle
        do_reset();
        first_hi = -1; hi_cnt = 0; pulse_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            req_ent = (i < 3);
            @(posedge clk);
            #1;
            if (cancela_ent) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
            if (somar) pulse_cnt++;
        end
        check("timeout_rise_cycle", first_hi, 2);
        check("timeout_open_cycles", hi_cnt, T);
        check("timeout_no_pulse", pulse_cnt, 0);
        check("timeout_idle", {31'd0, ocupado}, 32'd0);

        // tie: both requests from the same edge, held; alternation expected
        do_reset();
        @(negedge clk);
        req_ent = 1'b1;
        req_sai = 1'b1;
        npulse = 0; ke = 0; ks = 0; both = 0;
        ord[0] = 9; ord[1] = 9; ord[2] = 9;
        for (int c = 0; c < 300 && npulse < 3; c++) begin
            @(negedge clk);
            pass_ent = (ke >= 1 && ke <= 3);
            pass_sai = (ks >= 1 && ks <= 3);
            @(posedge clk);
            #1;
            if (cancela_ent && cancela_sai) both = 1;
            if (somar) begin
                if (npulse < 3) ord[npulse] = decrem;
                npulse++;
            end
            ke = cancela_ent ? ke + 1 : 0;
            ks = cancela_sai ? ks + 1 : 0;
        end
        req_ent = 1'b0; req_sai = 1'b0; pass_ent = 1'b0; pass_sai = 1'b0;
        check("tie_pulses", npulse, 3);
        check("tie_first_exit", ord[0], 1);
        check("tie_second_entry", ord[1], 0);
        check("tie_third_exit", ord[2], 1);
        check("tie_single_barrier", {31'd0, both}, 32'd0);

        // reset while a car is under the entry barrier
        do_reset();
        @(negedge clk);
        req_ent = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (cancela_ent) got = 1;
        end
        check("midpassa_granted", {31'd0, got}, 32'd1);
        req_ent  = 1'b0;
        pass_ent = 1'b1;
        repeat (6) @(negedge clk);
        check("midpassa_open", {30'd0, cancela_ent, ocupado}, 32'd3);
        reset = 1'b1;
        #1;
        check("midpassa_reset_close", {30'd0, cancela_ent, ocupado}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        pass_ent = 1'b0;
        pulse_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (somar || cancela_ent) pulse_cnt++;
        end
        check("midpassa_no_pulse", pulse_cnt, 0);

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        pins = '0;
        ch   = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) pins[b] = ~pins[b];
            if ($urandom_range(39) == 0) ch = ~ch;
            {pass_sai, req_sai, pass_ent, req_ent} = pins;
            cheio = ch;
            @(posedge clk);
            model_step(pins, ch);
            #1;
            check($sformatf("random_c%0d", c), {26'd0, outs()}, {26'd0, model_out()});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
